// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one combinational FP multiplier between two requesters.
// One transaction in flight: accept -> multiply -> hold product until the owner takes it.
module fp_mul_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic [XLEN-1:0] resp0_result,
    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [XLEN-1:0] resp1_result,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    input  logic [XLEN-1:0] mul_result,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic            last_grant_q;
    logic            owner_q;
    logic [XLEN-1:0] mul_a_q;
    logic [XLEN-1:0] mul_b_q;
    logic [XLEN-1:0] result_q;
    logic            resp0_valid_q;
    logic            resp1_valid_q;
    logic            busy_q;

    logic            grant_d;
    logic            req0_ready_raw;
    logic            req1_ready_raw;
    logic            resp_taken;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_d = last_grant_q;
        if (req0_valid && !req1_valid) begin
            grant_d = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant_d = 1'b1;
        end else if (req0_valid && req1_valid) begin
            grant_d = ~last_grant_q;
        end
    end

    assign req0_ready_raw = (state_q == IDLE) && req0_valid && !grant_d;
    assign req1_ready_raw = (state_q == IDLE) && req1_valid &&  grant_d;
    assign resp_taken     = owner_q ? resp1_ready : resp0_ready;

    // The FSM flops see rst only through their async reset; the raw readies suffice there.
    assign req0_ready = req0_ready_raw && !rst;
    assign req1_ready = req1_ready_raw && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            result_q      <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_ready_raw || req1_ready_raw) begin
                        mul_a_q      <= grant_d ? req1_a : req0_a;
                        mul_b_q      <= grant_d ? req1_b : req0_b;
                        owner_q      <= grant_d;
                        last_grant_q <= grant_d;
                        busy_q       <= 1'b1;
                        state_q      <= MUL;
                    end
                end
                MUL: begin
                    result_q      <= mul_result;
                    resp0_valid_q <= !owner_q;
                    resp1_valid_q <=  owner_q;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (resp_taken) begin
                        resp0_valid_q <= 1'b0;
                        resp1_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign resp0_valid  = resp0_valid_q;
    assign resp1_valid  = resp1_valid_q;
    assign resp0_result = result_q;
    assign resp1_result = result_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_fp_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp0_result, resp1_result;
    logic [31:0] mul_a, mul_b, mul_result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_mul_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result), .busy(busy)
    );

    // Stand-in for the shared multiplier: exact for the directed pairs, a scramble otherwise.
    function automatic logic [31:0] fake_mul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40100000;
        if (a == 32'hC0000000 && b == 32'h3F000000) return 32'hBF800000;
        return (a ^ {b[15:0], b[31:16]}) + 32'h9E3779B9;
    endfunction
    assign mul_result = fake_mul(mul_a, mul_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Accept observation, sampled with pre-edge values.
    logic acc0_seen = 1'b0;
    logic acc1_seen = 1'b0;
    int   cyc = 0;
    int   grant_log[$];
    int   acc_cyc[$];
    always @(posedge clk) begin
        acc0_seen <= req0_valid && req0_ready;
        acc1_seen <= req1_valid && req1_ready;
        if (req0_valid && req0_ready) begin grant_log.push_back(0); acc_cyc.push_back(cyc); end
        if (req1_valid && req1_ready) begin grant_log.push_back(1); acc_cyc.push_back(cyc); end
        cyc = cyc + 1;
    end

    // Reference model: at most one transaction record, aged in cycles since acceptance.
    logic        m_busy = 1'b0, m_own = 1'b0, m_last = 1'b1;
    int          m_age = 0;
    logic [31:0] m_a = '0, m_b = '0;
    always @(negedge clk) begin
        logic e_r0, e_r1, e_rv0, e_rv1;
        if (rst) begin
            m_busy = 1'b0; m_own = 1'b0; m_last = 1'b1; m_age = 0; m_a = '0; m_b = '0;
            check("rst_req0_ready", req0_ready, 0);
            check("rst_req1_ready", req1_ready, 0);
            check("rst_resp0_valid", resp0_valid, 0);
            check("rst_resp1_valid", resp1_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_mul_a", mul_a, 0);
            check("rst_mul_b", mul_b, 0);
        end else begin
            e_r0  = !m_busy && req0_valid && (!req1_valid || m_last);
            e_r1  = !m_busy && req1_valid && !e_r0;
            e_rv0 = m_busy && (m_age >= 1) && !m_own;
            e_rv1 = m_busy && (m_age >= 1) &&  m_own;
            check("model_req0_ready", req0_ready, e_r0);
            check("model_req1_ready", req1_ready, e_r1);
            check("model_resp0_valid", resp0_valid, e_rv0);
            check("model_resp1_valid", resp1_valid, e_rv1);
            check("model_busy", busy, m_busy);
            check("model_mul_a", mul_a, m_a);
            check("model_mul_b", mul_b, m_b);
            if (e_rv0) check("model_resp0_result", resp0_result, fake_mul(m_a, m_b));
            if (e_rv1) check("model_resp1_result", resp1_result, fake_mul(m_a, m_b));
            if (e_r0 || e_r1) begin
                m_busy = 1'b1; m_age = 0; m_own = e_r1; m_last = e_r1;
                m_a = e_r1 ? req1_a : req0_a;
                m_b = e_r1 ? req1_b : req0_b;
            end else if (m_busy) begin
                if (m_age == 0) begin
                    m_age = 1;
                end else if (m_own ? resp1_ready : resp0_ready) begin
                    $display("txn owner=%0d a=%08h b=%08h result=%08h", m_own, m_a, m_b, fake_mul(m_a, m_b));
                    m_busy = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b1; resp1_ready = 1'b1;
        while (busy && n < 20) begin tick(); n++; end
        check("drain_busy", busy, 0);
    endtask

    initial begin
        int n0, n;
        logic found;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        resp0_ready = 0; resp1_ready = 0;
        do_reset();

        // Single request from requester 0.
        req0_valid = 1; req0_a = 32'h40000000; req0_b = 32'h40400000; resp0_ready = 1;
        @(negedge clk);
        check("single_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 0;
        @(negedge clk);
        check("single_mul_a", mul_a, 32'h40000000);
        check("single_resp0_early", resp0_valid, 0);
        tick();
        @(negedge clk);
        check("single_resp0_valid", resp0_valid, 1);
        check("single_resp0_result", resp0_result, 32'h40C00000);
        check("single_resp1_valid", resp1_valid, 0);
        tick();
        drain();

        // Tie after reset: requester 0 first, then alternate while both stay valid.
        do_reset();
        grant_log.delete();
        req0_valid = 1; req0_a = $urandom; req0_b = $urandom;
        req1_valid = 1; req1_a = 32'h3FC00000; req1_b = 32'h3FC00000;
        resp0_ready = 1; resp1_ready = 1;
        @(negedge clk);
        check("tie_req0_ready", req0_ready, 1);
        check("tie_req1_ready", req1_ready, 0);
        tick();
        repeat (11) begin
            if (acc0_seen) begin req0_a = $urandom; req0_b = $urandom; end
            @(negedge clk);
            if (resp1_valid) check("tie_resp1_result", resp1_result, 32'h40100000);
            tick();
        end
        check("tie_grant_count", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size() && i < 4; i++) check("tie_grant_order", grant_log[i], i % 2);
        drain();

        // Backpressure on requester 1 for 10 cycles.
        req1_valid = 1; req1_a = 32'hC0000000; req1_b = 32'h3F000000; resp1_ready = 0;
        @(negedge clk);
        check("bp_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 0; req0_valid = 1; req0_a = $urandom; req0_b = $urandom;
        tick();
        repeat (10) begin
            @(negedge clk);
            check("bp_resp1_valid", resp1_valid, 1);
            check("bp_resp1_result", resp1_result, 32'hBF800000);
            check("bp_req0_ready", req0_ready, 0);
            check("bp_req1_ready", req1_ready, 0);
            tick();
        end
        resp1_ready = 1;
        @(negedge clk);
        check("bp_hold_last", resp1_valid, 1);
        tick();
        @(negedge clk);
        check("bp_idle_busy", busy, 0);
        check("bp_idle_req0_ready", req0_ready, 1);
        tick();
        drain();

        // Back-to-back on requester 0: one accept every 3 cycles.
        acc_cyc.delete();
        req0_valid = 1; req0_a = $urandom; req0_b = $urandom; resp0_ready = 1;
        repeat (15) begin
            tick();
            if (acc0_seen) begin req0_a = $urandom; req0_b = $urandom; end
        end
        check("b2b_accepts", acc_cyc.size(), 5);
        for (int i = 1; i < acc_cyc.size(); i++) check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
        drain();

        // Reset while the response is pending.
        req0_valid = 1; req0_a = $urandom; req0_b = $urandom; resp0_ready = 0;
        tick();
        req0_valid = 0;
        tick();
        @(negedge clk);
        check("mid_pre_resp0_valid", resp0_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_resp0_valid", resp0_valid, 0);
        check("mid_mul_a", mul_a, 0);
        check("mid_mul_b", mul_b, 0);
        check("mid_busy", busy, 0);
        check("mid_req0_ready", req0_ready, 0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        req0_valid = 1; req0_a = $urandom; req0_b = $urandom;
        req1_valid = 1; req1_a = $urandom; req1_b = $urandom;
        resp0_ready = 1; resp1_ready = 1;
        @(negedge clk);
        check("mid_tie_req0_ready", req0_ready, 1);
        check("mid_tie_req1_ready", req1_ready, 0);
        tick();
        drain();

        // Starvation: requester 1 pends while requester 0 keeps re-requesting.
        req0_valid = 1; req0_a = $urandom; req0_b = $urandom;
        tick();
        req1_valid = 1; req1_a = $urandom; req1_b = $urandom;
        req0_a = $urandom; req0_b = $urandom;
        n0 = 0; n = 0; found = 0;
        while (!found && n < 20) begin
            tick(); n++;
            if (acc1_seen) found = 1;
            if (acc0_seen) begin n0++; req0_a = $urandom; req0_b = $urandom; end
        end
        check("starve_req1_served", found, 1);
        check("starve_req0_overtakes", n0, 0);
        drain();

        // Randomized traffic; pending requests hold their operands (or occasionally withdraw).
        repeat (1500) begin
            tick();
            if (!req0_valid || acc0_seen) begin
                req0_valid = ($urandom % 3) != 0; req0_a = $urandom; req0_b = $urandom;
            end else if ($urandom % 16 == 0) begin
                req0_valid = 0;
            end
            if (!req1_valid || acc1_seen) begin
                req1_valid = ($urandom % 3) != 0; req1_a = $urandom; req1_b = $urandom;
            end else if ($urandom % 16 == 0) begin
                req1_valid = 0;
            end
            resp0_ready = ($urandom % 4) != 0;
            resp1_ready = ($urandom % 4) != 0;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
